ecall_handler: RTL
==================

# ecall_handler

Environment-call responder for the non-pipelined core. The execute stage flags a retiring ECALL; this block services it. It stalls the core while servicing, emits console characters over a valid/ready port, returns a status value for writeback into a0, and halts the core on exit. It sits beside execute and drives the core-wide stall and halt lines.

## Interface
Parameters:
- DATA_WIDTH, 32, register/data width
- ADDRESS_WIDTH, 32, PC width
- CNT_WIDTH, 16, width of the serviced-ecall counter

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset; one clock, asynchronous, active-low
- i_ecall  in  1  ECALL in execute; held high by the core while o_stall is high
- i_pc  in  ADDRESS_WIDTH  PC of the ECALL instruction
- i_a7  in  DATA_WIDTH  syscall number (x17)
- i_a0  in  DATA_WIDTH  syscall argument (x10)
- o_stall  out  1  freeze PC/regfile update
- o_console_valid  out  1  console byte valid
- o_console_data  out  8  console byte
- i_console_ready  in  1  console accepts byte
- o_ret_valid  out  1  one-cycle strobe: write o_ret_data to a0
- o_ret_data  out  DATA_WIDTH  syscall return value
- o_halt  out  1  core halted (sticky)
- o_exit_code  out  DATA_WIDTH  a0 captured at exit
- o_halt_pc  out  ADDRESS_WIDTH  PC of the exit ECALL
- o_err  out  1  sticky: an unsupported syscall was seen
- o_ecall_count  out  CNT_WIDTH  number of accepted ecalls, saturating

## Operation
- States: IDLE, PUTC, DONE, HALT.
- IDLE: an ecall is accepted when i_ecall=1. On acceptance, capture i_a7, i_a0 and i_pc, and increment o_ecall_count (saturates at all-ones). Next state by captured a7:
  - 64 (putchar) -> PUTC.
  - 93 (exit) -> HALT.
  - Any other value -> DONE, with o_ret_data = all-ones and o_err set.
- PUTC:
  - o_console_valid=1, o_console_data=a0[7:0].
  - Both are held stable until i_console_ready=1; valid never drops without a handshake.
  - On handshake -> DONE, with o_ret_data=1.
- DONE:
  - o_ret_valid=1 for exactly one cycle; o_stall=0 so the core retires the ECALL.
  - Next state is IDLE unconditionally; i_ecall is ignored in DONE.
- HALT: o_halt=1, o_exit_code=captured a0, o_halt_pc=captured PC, o_stall=1. Terminal until reset. i_ecall is ignored and the counter is frozen.
- o_stall is combinational: 1 when (IDLE and i_ecall), or in PUTC, or in HALT; 0 otherwise.
- o_ret_data is registered and holds its last value outside DONE.

## Timing
- Reset values (asynchronous, immediate): state IDLE; o_stall=0 (when i_ecall=0), o_console_valid=0, o_console_data=0, o_ret_valid=0, o_ret_data=0, o_halt=0, o_exit_code=0, o_halt_pc=0, o_err=0, o_ecall_count=0.
- Cycle numbering: cycle 0 is the cycle in which i_ecall rises in IDLE.
- Unsupported syscall: 1 stall cycle. Cycle 0 stall; cycle 1 DONE with ret strobe.
- putchar with ready always high: cycle 1 valid and handshake; cycle 2 DONE. Total 2 stall cycles.
- putchar with back-pressure: one extra stall cycle per cycle ready is low.
- exit: o_halt rises at cycle 1 and remains high.
- Back-to-back ECALLs: a new ECALL presented in the cycle after DONE is accepted normally.
- Reset asserted mid-PUTC: o_console_valid drops asynchronously; no byte is counted as sent.
- o_ecall_count saturation: the count stays at 2^CNT_WIDTH-1; no wrap.

## Test plan
- Reset released with i_ecall=0 -> all outputs 0; state IDLE for 10 cycles.
- a7=64, a0=0x41, ready tied high -> valid+data 0x41 at cycle 1; o_ret_valid with ret 1 at cycle 2; stall high for cycles 0–1 only; count=1.
- a7=64, a0=0x1FF, ready low for 3 cycles -> data 0x FF held stable and valid held 4 cycles; one handshake; ret strobe on the cycle after the handshake.
- a7=7 -> o_ret_data=0xFFFFFFFF with strobe at cycle 1; o_err=1 and remains set after a following valid putchar.
- a7=93, a0=5, pc=0x100 -> o_halt=1, exit_code=5, halt_pc=0x100 from cycle 1; later ECALLs do not change the count or the console outputs.
- Reset pulsed while in PUTC with ready=0 -> valid drops in the same cycle; after release, state IDLE and count=0.

Source files
------------

// File: rtl/ecall_handler.sv
`default_nettype none
// ============================================================================
// Module      : ecall_handler
// Description : Services ECALLs that retire from the execute stage. It stalls
//               the core while busy, emits putchar bytes over a valid/ready
//               console port, returns a status value for a0, and halts the
//               core on exit.
// Revision    : 1.0 - initial release
// ============================================================================
module ecall_handler #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ecall,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0]    i_a7,
  input  logic [DATA_WIDTH-1:0]    i_a0,
  output logic                     o_stall,
  output logic                     o_console_valid,
  output logic [7:0]               o_console_data,
  input  logic                     i_console_ready,
  output logic                     o_ret_valid,
  output logic [DATA_WIDTH-1:0]    o_ret_data,
  output logic                     o_halt,
  output logic [DATA_WIDTH-1:0]    o_exit_code,
  output logic [ADDRESS_WIDTH-1:0] o_halt_pc,
  output logic                     o_err,
  output logic [CNT_WIDTH-1:0]     o_ecall_count
);

  // Syscall numbers understood by this block.
  localparam logic [DATA_WIDTH-1:0] C_SYS_PUTC = DATA_WIDTH'(64);
  localparam logic [DATA_WIDTH-1:0] C_SYS_EXIT = DATA_WIDTH'(93);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUTC = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t                   state_q,     state_d;
  logic [DATA_WIDTH-1:0]    a0_q,        a0_d;
  logic [DATA_WIDTH-1:0]    ret_data_q,  ret_data_d;
  logic                     err_q,       err_d;
  logic [CNT_WIDTH-1:0]     count_q,     count_d;
  logic [DATA_WIDTH-1:0]    exit_code_q, exit_code_d;
  logic [ADDRESS_WIDTH-1:0] halt_pc_q,   halt_pc_d;

  // Next-state logic: acceptance in IDLE captures arguments and bumps the
  // counter; the syscall number alone picks the service path.
  always_comb begin
    state_d     = state_q;
    a0_d        = a0_q;
    ret_data_d  = ret_data_q;
    err_d       = err_q;
    count_d     = count_q;
    exit_code_d = exit_code_q;
    halt_pc_d   = halt_pc_q;

    case (state_q)
      S_IDLE: begin
        if (i_ecall) begin
          a0_d = i_a0;
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          if (i_a7 == C_SYS_PUTC) begin
            state_d = S_PUTC;
          end else if (i_a7 == C_SYS_EXIT) begin
            state_d     = S_HALT;
            exit_code_d = i_a0;
            halt_pc_d   = i_pc;
          end else begin
            state_d    = S_DONE;
            ret_data_d = {DATA_WIDTH{1'b1}};
            err_d      = 1'b1;
          end
        end
      end
      S_PUTC: begin
        // Valid stays asserted until the console takes the byte.
        if (i_console_ready) begin
          state_d    = S_DONE;
          ret_data_d = DATA_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-value registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      a0_q        <= '0;
      ret_data_q  <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
      exit_code_q <= '0;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      a0_q        <= a0_d;
      ret_data_q  <= ret_data_d;
      err_q       <= err_d;
      count_q     <= count_d;
      exit_code_q <= exit_code_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

  // Stall is combinational so the core freezes in the very cycle the ECALL
  // appears; DONE releases it so the instruction retires.
  assign o_stall         = ((state_q == S_IDLE) && i_ecall) ||
                           (state_q == S_PUTC) || (state_q == S_HALT);
  assign o_console_valid = (state_q == S_PUTC);
  assign o_console_data  = (state_q == S_PUTC) ? a0_q[7:0] : 8'h00;
  assign o_ret_valid     = (state_q == S_DONE);
  assign o_ret_data      = ret_data_q;
  assign o_halt          = (state_q == S_HALT);
  assign o_exit_code     = exit_code_q;
  assign o_halt_pc       = halt_pc_q;
  assign o_err           = err_q;
  assign o_ecall_count   = count_q;

endmodule
`default_nettype wire
